cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arb_pkg.sv | 38 +++
 rtl/cache_mem_arbiter_rr_arb_tree.sv | 59 +++++
 rtl/cache_mem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// cache_mem_arb_pkg
// Shared types and constants for the cache-to-memory arbiter:
//   port_e        - requester identities (icache refill, dcache read/write)
//   tt_entry_t    - one transaction-table entry (valid, origin, upstream tid,
//                   write flag)
//   cnt_width()   - width of a counter that must hold 0..max_count
//   WrCntWidth    - write-counter width for the default store limit
// ----------------------------------------------------------------------------
package cache_mem_arb_pkg;

    typedef enum logic [1:0] {
        PORT_ICACHE = 2'd0,
        PORT_DREAD  = 2'd1,
        PORT_DWRITE = 2'd2
    } port_e;

    // Origin and tid fields are sized for the largest supported configuration
    // (up to 4 ports, up to 8-bit tids); narrower configurations zero-extend.
    localparam int unsigned PortIdxWidth = 2;
    localparam int unsigned MaxTidWidth  = 8;

    localparam int unsigned DefaultMaxOutstandingStores = 7;

    function automatic int unsigned cnt_width(input int unsigned max_count);
        return $clog2(max_count + 1);
    endfunction

    localparam int unsigned WrCntWidth = cnt_width(DefaultMaxOutstandingStores);

    typedef struct packed {
        logic                    valid;
        logic [PortIdxWidth-1:0] origin;
        logic [MaxTidWidth-1:0]  tid;
        logic                    is_write;
    } tt_entry_t;

endpackage

// File: rtl/cache_mem_arbiter_rr_arb_tree.sv
// ----------------------------------------------------------------------------
// rr_arb_tree
// Round-robin selector. The search starts at the input after the last
// accepted grant; the pointer only moves when the grant is accepted.
//   clk_i, rst_ni  - clock, async active-low reset (pointer -> input 0 first)
//   req_i          - eligible requesters
//   accept_i       - the current grant is taken this cycle
//   gnt_valid_o    - some requester selected
//   gnt_idx_o      - index of the selected requester
// ----------------------------------------------------------------------------
module rr_arb_tree #(
    parameter int unsigned NumIn    = 3,
    parameter int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumIn-1:0]    req_i,
    input  logic                accept_i,
    output logic                gnt_valid_o,
    output logic [IdxWidth-1:0] gnt_idx_o
);

    logic [IdxWidth-1:0] last_q, last_d;
    logic [IdxWidth:0]   cand;

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        cand        = '0;
        for (int i = 1; i <= int'(NumIn); i++) begin
            // Extra MSB so last+i cannot overflow before the wrap.
            cand = {1'b0, last_q} + (IdxWidth+1)'(i);
            if (cand >= (IdxWidth+1)'(NumIn)) begin
                cand = cand - (IdxWidth+1)'(NumIn);
            end
            if (!gnt_valid_o && req_i[cand[IdxWidth-1:0]]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand[IdxWidth-1:0];
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept_i && gnt_valid_o) begin
            last_d = gnt_idx_o;
        end
    end

    // Reset to the last input so input 0 is searched first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= IdxWidth'(NumIn - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cache_mem_arbiter
// Arbitrates icache refills, dcache reads and dcache writes onto one memory
// request channel and routes tagged responses back to the requester.
//   clk_i, rst_ni              - clock, async active-low reset
//   req_valid_i / req_ready_o  - per-port request handshake
//   req_addr/we/wdata/tid_i    - per-port request payload
//   mem_req_valid_o / _ready_i - downstream request handshake
//   mem_req_addr/we/wdata/tid_o- downstream payload (tid = table index)
//   mem_rsp_valid/tid/rdata_i  - downstream response, always accepted
//   rsp_valid/tid/rdata_o      - response routed to its origin port
// ----------------------------------------------------------------------------
module cache_mem_arbiter
    import cache_mem_arb_pkg::*;
#(
    parameter int unsigned NrPorts             = 3,
    parameter int unsigned AddrWidth           = 64,
    parameter int unsigned LineWidth           = 128,
    parameter int unsigned TidWidth            = 2,
    parameter int unsigned MaxOutstandingStores = 7
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NrPorts-1:0]                 req_valid_i,
    output logic [NrPorts-1:0]                 req_ready_o,
    input  logic [NrPorts-1:0][AddrWidth-1:0]  req_addr_i,
    input  logic [NrPorts-1:0]                 req_we_i,
    input  logic [NrPorts-1:0][LineWidth-1:0]  req_wdata_i,
    input  logic [NrPorts-1:0][TidWidth-1:0]   req_tid_i,
    output logic                               mem_req_valid_o,
    input  logic                               mem_req_ready_i,
    output logic [AddrWidth-1:0]               mem_req_addr_o,
    output logic                               mem_req_we_o,
    output logic [LineWidth-1:0]               mem_req_wdata_o,
    output logic [TidWidth-1:0]                mem_req_tid_o,
    input  logic                               mem_rsp_valid_i,
    input  logic [TidWidth-1:0]                mem_rsp_tid_i,
    input  logic [LineWidth-1:0]               mem_rsp_rdata_i,
    output logic [NrPorts-1:0]                 rsp_valid_o,
    output logic [TidWidth-1:0]                rsp_tid_o,
    output logic [LineWidth-1:0]               rsp_rdata_o
);

    localparam int unsigned NrEntries = 2 ** TidWidth;
    localparam int unsigned PortW     = (NrPorts > 1) ? $clog2(NrPorts) : 1;
    localparam int unsigned CntW      = cnt_width(MaxOutstandingStores);

    tt_entry_t            tt_q [NrEntries];
    tt_entry_t            tt_d [NrEntries];
    logic [CntW-1:0]      wr_cnt_q, wr_cnt_d, wr_cnt_eff;
    logic                 oreg_valid_q, oreg_valid_d;
    logic [AddrWidth-1:0] oreg_addr_q;
    logic                 oreg_we_q;
    logic [LineWidth-1:0] oreg_wdata_q;
    logic [TidWidth-1:0]  oreg_tid_q;

    tt_entry_t            rsp_entry;
    logic                 rsp_hit, rsp_wr;
    logic                 any_free;
    logic [TidWidth-1:0]  alloc_idx;
    logic                 wr_full;
    logic [NrPorts-1:0]   elig;
    logic                 gnt_valid;
    logic [PortW-1:0]     gnt_idx;
    logic                 can_load, accept, gnt_we;
    logic                 unused_rsp_entry;

    // ---------------- response routing (combinational) ----------------
    assign rsp_entry = tt_q[mem_rsp_tid_i];
    assign rsp_hit   = rst_ni & mem_rsp_valid_i & rsp_entry.valid;
    assign rsp_wr    = rsp_hit & rsp_entry.is_write;
    assign unused_rsp_entry = ^rsp_entry;

    always_comb begin
        rsp_valid_o = '0;
        if (rsp_hit) begin
            rsp_valid_o[rsp_entry.origin] = 1'b1;
        end
    end

    assign rsp_tid_o   = rsp_entry.tid[TidWidth-1:0];
    assign rsp_rdata_o = mem_rsp_rdata_i;

    // ---------------- free list with same-cycle bypass ----------------
    // Descending scan so the lowest free index is the one left selected.
    always_comb begin
        any_free  = 1'b0;
        alloc_idx = '0;
        for (int i = int'(NrEntries) - 1; i >= 0; i--) begin
            if (!tt_q[i].valid || (rsp_hit && (mem_rsp_tid_i == TidWidth'(i)))) begin
                any_free  = 1'b1;
                alloc_idx = TidWidth'(i);
            end
        end
    end

    // A write response retiring this cycle already makes room for a new write.
    assign wr_cnt_eff = wr_cnt_q - CntW'(rsp_wr);
    assign wr_full    = (wr_cnt_eff >= CntW'(MaxOutstandingStores));

    always_comb begin
        for (int p = 0; p < int'(NrPorts); p++) begin
            elig[p] = req_valid_i[p] & any_free & (~req_we_i[p] | ~wr_full);
        end
    end

    // ---------------- arbitration ----------------
    assign can_load = ~oreg_valid_q | mem_req_ready_i;
    assign accept   = rst_ni & gnt_valid & can_load;
    assign gnt_we   = req_we_i[gnt_idx];

    rr_arb_tree #(
        .NumIn    (NrPorts),
        .IdxWidth (PortW)
    ) u_rr_arb_tree (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (elig),
        .accept_i    (accept),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    // ---------------- table, write count, output register ----------------
    always_comb begin
        tt_d = tt_q;
        if (rsp_hit) begin
            tt_d[mem_rsp_tid_i].valid = 1'b0;
        end
        // Allocation after the free so a bypassed entry ends up valid.
        if (accept) begin
            tt_d[alloc_idx].valid    = 1'b1;
            tt_d[alloc_idx].origin   = PortIdxWidth'(gnt_idx);
            tt_d[alloc_idx].tid      = MaxTidWidth'(req_tid_i[gnt_idx]);
            tt_d[alloc_idx].is_write = gnt_we;
        end
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if ((accept && gnt_we) && !rsp_wr) begin
            if (wr_cnt_q != CntW'(MaxOutstandingStores)) begin
                wr_cnt_d = wr_cnt_q + CntW'(1);
            end
        end else if (rsp_wr && !(accept && gnt_we)) begin
            if (wr_cnt_q != '0) begin
                wr_cnt_d = wr_cnt_q - CntW'(1);
            end
        end
    end

    always_comb begin
        oreg_valid_d = oreg_valid_q;
        if (accept) begin
            oreg_valid_d = 1'b1;
        end else if (mem_req_ready_i) begin
            oreg_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NrEntries); i++) begin
                tt_q[i] <= '0;
            end
            wr_cnt_q     <= '0;
            oreg_valid_q <= 1'b0;
        end else begin
            tt_q         <= tt_d;
            wr_cnt_q     <= wr_cnt_d;
            oreg_valid_q <= oreg_valid_d;
        end
    end

    // Payload only loads on accept, so it holds while the channel stalls.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            oreg_addr_q  <= req_addr_i[gnt_idx];
            oreg_we_q    <= gnt_we;
            oreg_wdata_q <= req_wdata_i[gnt_idx];
            oreg_tid_q   <= alloc_idx;
        end
    end

    assign mem_req_valid_o = oreg_valid_q;
    assign mem_req_addr_o  = oreg_addr_q;
    assign mem_req_we_o    = oreg_we_q;
    assign mem_req_wdata_o = oreg_wdata_q;
    assign mem_req_tid_o   = oreg_tid_q;

`ifndef SYNTHESIS
    // A response whose tid has no live entry is dropped; flag it in simulation.
    always_ff @(posedge clk_i) begin
        if (rst_ni && mem_rsp_valid_i) begin
            assert (tt_q[mem_rsp_tid_i].valid)
            else $warning("cache_mem_arbiter: response for unallocated tid %0d dropped", mem_rsp_tid_i);
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        req_valid, req_ready, req_we;
    logic [2:0][63:0]  req_addr;
    logic [2:0][127:0] req_wdata;
    logic [2:0][2:0]   req_tid;
    logic              mem_req_valid, mem_req_ready, mem_req_we;
    logic [63:0]       mem_req_addr;
    logic [127:0]      mem_req_wdata;
    logic [2:0]        mem_req_tid;
    logic              mem_rsp_valid;
    logic [2:0]        mem_rsp_tid;
    logic [127:0]      mem_rsp_rdata;
    logic [2:0]        rsp_valid, rsp_tid;
    logic [127:0]      rsp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .NrPorts(3), .AddrWidth(64), .LineWidth(128), .TidWidth(3), .MaxOutstandingStores(7)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_we_i(req_we), .req_wdata_i(req_wdata), .req_tid_i(req_tid),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_req_addr_o(mem_req_addr), .mem_req_we_o(mem_req_we),
        .mem_req_wdata_o(mem_req_wdata), .mem_req_tid_o(mem_req_tid),
        .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_tid_i(mem_rsp_tid), .mem_rsp_rdata_i(mem_rsp_rdata),
        .rsp_valid_o(rsp_valid), .rsp_tid_o(rsp_tid), .rsp_rdata_o(rsp_rdata)
    );

    typedef struct {
        logic [2:0] rv;
        logic [2:0] we;
        logic       rspv;
        logic [2:0] rtid;
        logic [2:0] e_rdy;
        logic       e_mv;
        logic [2:0] e_mtid;
        logic [1:0] e_mport;
        logic       e_mwe;
        logic [2:0] e_rspv;
        logic [2:0] e_rtid;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic [2:0] rv, input logic [2:0] we, input logic rspv,
                                input logic [2:0] rtid, input logic [2:0] e_rdy, input logic e_mv,
                                input logic [2:0] e_mtid, input logic [1:0] e_mport, input logic e_mwe,
                                input logic [2:0] e_rspv, input logic [2:0] e_rtid);
        vec_t v;
        v.rv = rv; v.we = we; v.rspv = rspv; v.rtid = rtid;
        v.e_rdy = e_rdy; v.e_mv = e_mv; v.e_mtid = e_mtid; v.e_mport = e_mport;
        v.e_mwe = e_mwe; v.e_rspv = e_rspv; v.e_rtid = e_rtid;
        return v;
    endfunction

    function automatic logic [63:0] addr_of(input logic [1:0] p);
        return 64'h1000 * (64'(p) + 64'd1);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rsp(input logic v, input logic [2:0] t);
        mem_rsp_valid = v;
        mem_rsp_tid   = t;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] snap;
        logic       got;

        // Each port has a distinct address, payload and upstream tid (1,2,3).
        for (int p = 0; p < 3; p++) begin
            req_addr[p]  = addr_of(2'(p));
            req_wdata[p] = {4{32'hC0DE_0000 + 32'(p)}};
            req_tid[p]   = 3'(p + 1);
        end
        rst_n = 1'b0; req_valid = 3'b111; req_we = 3'b000; mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_tid = 3'd0; mem_rsp_rdata = '0;

        // Outputs quiet while reset is held, even with activity on the inputs.
        @(negedge clk);
        chk("rst.req_ready", 128'(req_ready), 128'(3'b000));
        chk("rst.mem_req_valid", 128'(mem_req_valid), 128'(1'b0));
        chk("rst.rsp_valid", 128'(rsp_valid), 128'(3'b000));
        next_cycle();
        rst_n = 1'b1; mem_rsp_valid = 1'b0;

        //             rv      we      rspv  rtid  | rdy     mv    mtid  mport mwe   rspv    rtid
        vecs[0]  = mk(3'b111, 3'b100, 1'b0, 3'd0, 3'b001, 1'b0, 3'd0, 2'd0, 1'b0, 3'b000, 3'd0);
        vecs[1]  = mk(3'b110, 3'b100, 1'b0, 3'd0, 3'b010, 1'b1, 3'd0, 2'd0, 1'b0, 3'b000, 3'd0);
        vecs[2]  = mk(3'b100, 3'b100, 1'b0, 3'd0, 3'b100, 1'b1, 3'd1, 2'd1, 1'b0, 3'b000, 3'd0);
        vecs[3]  = mk(3'b000, 3'b000, 1'b1, 3'd1, 3'b000, 1'b1, 3'd2, 2'd2, 1'b1, 3'b010, 3'd2);
        vecs[4]  = mk(3'b100, 3'b100, 1'b0, 3'd0, 3'b100, 1'b0, 3'd0, 2'd0, 1'b0, 3'b000, 3'd0);
        vecs[5]  = mk(3'b000, 3'b000, 1'b1, 3'd1, 3'b000, 1'b1, 3'd1, 2'd2, 1'b1, 3'b100, 3'd3);
        vecs[6]  = mk(3'b010, 3'b000, 1'b0, 3'd0, 3'b010, 1'b0, 3'd0, 2'd0, 1'b0, 3'b000, 3'd0);
        vecs[7]  = mk(3'b000, 3'b000, 1'b1, 3'd2, 3'b000, 1'b1, 3'd1, 2'd1, 1'b0, 3'b100, 3'd3);
        vecs[8]  = mk(3'b000, 3'b000, 1'b1, 3'd0, 3'b000, 1'b0, 3'd0, 2'd0, 1'b0, 3'b001, 3'd1);
        vecs[9]  = mk(3'b000, 3'b000, 1'b1, 3'd1, 3'b000, 1'b0, 3'd0, 2'd0, 1'b0, 3'b010, 3'd2);
        vecs[10] = mk(3'b111, 3'b000, 1'b0, 3'd0, 3'b100, 1'b0, 3'd0, 2'd0, 1'b0, 3'b000, 3'd0);
        vecs[11] = mk(3'b011, 3'b000, 1'b0, 3'd0, 3'b001, 1'b1, 3'd0, 2'd2, 1'b0, 3'b000, 3'd0);
        vecs[12] = mk(3'b010, 3'b000, 1'b0, 3'd0, 3'b010, 1'b1, 3'd1, 2'd0, 1'b0, 3'b000, 3'd0);
        vecs[13] = mk(3'b000, 3'b000, 1'b0, 3'd0, 3'b000, 1'b1, 3'd2, 2'd1, 1'b0, 3'b000, 3'd0);
        vecs[14] = mk(3'b000, 3'b000, 1'b1, 3'd0, 3'b000, 1'b0, 3'd0, 2'd0, 1'b0, 3'b100, 3'd3);
        vecs[15] = mk(3'b000, 3'b000, 1'b1, 3'd1, 3'b000, 1'b0, 3'd0, 2'd0, 1'b0, 3'b001, 3'd1);
        vecs[16] = mk(3'b000, 3'b000, 1'b1, 3'd2, 3'b000, 1'b0, 3'd0, 2'd0, 1'b0, 3'b010, 3'd2);

        for (int i = 0; i < 17; i++) begin
            req_valid     = vecs[i].rv;
            req_we        = vecs[i].we;
            drive_rsp(vecs[i].rspv, vecs[i].rtid);
            mem_rsp_rdata = {4{32'hA5A5_0000 + 32'(i)}};
            @(negedge clk);
            chk($sformatf("v%0d.req_ready", i), 128'(req_ready), 128'(vecs[i].e_rdy));
            chk($sformatf("v%0d.mem_req_valid", i), 128'(mem_req_valid), 128'(vecs[i].e_mv));
            if (vecs[i].e_mv) begin
                chk($sformatf("v%0d.mem_req_tid", i), 128'(mem_req_tid), 128'(vecs[i].e_mtid));
                chk($sformatf("v%0d.mem_req_addr", i), 128'(mem_req_addr), 128'(addr_of(vecs[i].e_mport)));
                chk($sformatf("v%0d.mem_req_we", i), 128'(mem_req_we), 128'(vecs[i].e_mwe));
            end
            chk($sformatf("v%0d.rsp_valid", i), 128'(rsp_valid), 128'(vecs[i].e_rspv));
            if (vecs[i].e_rspv != 3'b000) begin
                chk($sformatf("v%0d.rsp_tid", i), 128'(rsp_tid), 128'(vecs[i].e_rtid));
                chk($sformatf("v%0d.rsp_rdata", i), rsp_rdata, {4{32'hA5A5_0000 + 32'(i)}});
            end
            next_cycle();
        end
        req_valid = 3'b000; drive_rsp(1'b0, 3'd0);

        // Fill the whole table with port-0 reads, then port 1 must wait
        // until tid 2 retires and reuse it in that same cycle.
        req_valid = 3'b001; req_we = 3'b000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("fill%0d.req_ready", k), 128'(req_ready), 128'(3'b001));
            next_cycle();
        end
        req_valid = 3'b010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("full%0d.req_ready", k), 128'(req_ready), 128'(3'b000));
            next_cycle();
        end
        drive_rsp(1'b1, 3'd2);
        @(negedge clk);
        chk("reuse.req_ready", 128'(req_ready), 128'(3'b010));
        chk("reuse.rsp_valid", 128'(rsp_valid), 128'(3'b001));
        next_cycle();
        req_valid = 3'b000; drive_rsp(1'b0, 3'd0);
        @(negedge clk);
        chk("reuse.mem_req_valid", 128'(mem_req_valid), 128'(1'b1));
        chk("reuse.mem_req_tid", 128'(mem_req_tid), 128'(3'd2));
        next_cycle();
        for (int t = 0; t < 8; t++) begin
            drive_rsp(1'b1, 3'(t));
            next_cycle();
        end
        drive_rsp(1'b0, 3'd0);

        // Seven writes in flight: the read goes through, the eighth write
        // waits for a write response (a read response is not enough).
        req_valid = 3'b100; req_we = 3'b100;
        for (int k = 0; k < 7; k++) next_cycle();
        req_valid = 3'b101;
        @(negedge clk);
        chk("wcap.read_granted", 128'(req_ready), 128'(3'b001));
        next_cycle();
        req_valid = 3'b100;
        @(negedge clk);
        chk("wcap.blocked0", 128'(req_ready), 128'(3'b000));
        next_cycle();
        drive_rsp(1'b1, 3'd7);
        @(negedge clk);
        chk("wcap.read_rsp", 128'(rsp_valid), 128'(3'b001));
        chk("wcap.blocked1", 128'(req_ready), 128'(3'b000));
        next_cycle();
        drive_rsp(1'b1, 3'd0);
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            if (req_ready == 3'b100) got = 1'b1;
            next_cycle();
            drive_rsp(1'b0, 3'd0);
            if (got) req_valid = 3'b000;
        end
        chk("wcap.unblocked", 128'(got), 128'(1'b1));
        req_valid = 3'b000;
        @(negedge clk);
        chk("wcap.count7", 128'(dut.wr_cnt_q), 128'(3'd7));
        next_cycle();
        for (int t = 0; t < 7; t++) begin
            drive_rsp(1'b1, 3'(t));
            @(negedge clk);
            chk($sformatf("wcap.drain%0d", t), 128'(rsp_valid), 128'(3'b100));
            next_cycle();
        end
        drive_rsp(1'b0, 3'd0);
        @(negedge clk);
        chk("wcap.count0", 128'(dut.wr_cnt_q), 128'(3'd0));
        next_cycle();

        // Downstream stall: payload holds, no further grants.
        mem_req_ready = 1'b0; req_we = 3'b000; req_valid = 3'b001;
        @(negedge clk);
        chk("stall.first_grant", 128'(req_ready), 128'(3'b001));
        next_cycle();
        req_valid = 3'b011;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d.req_ready", k), 128'(req_ready), 128'(3'b000));
            chk($sformatf("stall%0d.mem_req_valid", k), 128'(mem_req_valid), 128'(1'b1));
            chk($sformatf("stall%0d.mem_req_addr", k), 128'(mem_req_addr), 128'(64'h1000));
            chk($sformatf("stall%0d.mem_req_tid", k), 128'(mem_req_tid), 128'(3'd0));
            next_cycle();
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("stall.release_grant", 128'(req_ready), 128'(3'b010));
        next_cycle();
        req_valid = 3'b000;
        @(negedge clk);
        chk("stall.next_tid", 128'(mem_req_tid), 128'(3'd1));
        next_cycle();
        for (int t = 0; t < 2; t++) begin
            drive_rsp(1'b1, 3'(t));
            next_cycle();
        end
        drive_rsp(1'b0, 3'd0);

        // Reset with transactions in flight: they are forgotten.
        req_valid = 3'b111; req_we = 3'b100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            snap = req_ready;
            next_cycle();
            req_valid = req_valid & ~snap;
        end
        req_valid = 3'b000;
        @(negedge clk);
        chk("inflight.count", 128'(dut.wr_cnt_q), 128'(3'd1));
        next_cycle();
        rst_n = 1'b0; req_valid = 3'b111; drive_rsp(1'b1, 3'd0);
        @(negedge clk);
        chk("rst2.req_ready", 128'(req_ready), 128'(3'b000));
        chk("rst2.mem_req_valid", 128'(mem_req_valid), 128'(1'b0));
        chk("rst2.rsp_valid", 128'(rsp_valid), 128'(3'b000));
        chk("rst2.count", 128'(dut.wr_cnt_q), 128'(3'd0));
        next_cycle();
        rst_n = 1'b1; req_valid = 3'b000; drive_rsp(1'b0, 3'd0);
        next_cycle();
        drive_rsp(1'b1, 3'd0);
        @(negedge clk);
        chk("stale.rsp_valid", 128'(rsp_valid), 128'(3'b000));
        chk("stale.count", 128'(dut.wr_cnt_q), 128'(3'd0));
        next_cycle();
        drive_rsp(1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
